// File: rtl/toy_eu_forward_tag_gen_pkg.sv
// Purpose: shared sizes, forwarding codes and EU payload types for the issue-side forward tag generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package toy_eu_forward_tag_gen_pkg;

    localparam int EU_NUM    = 4;
    localparam int PREG_W    = 7;
    localparam int REG_WIDTH = 64;
    localparam int RF_WR_LAT = 2;
    localparam int ID_W      = $clog2(EU_NUM);

    // Where the EU-input mux takes the operand from.
    localparam logic [1:0] FWD_CYC_NEXT = 2'b10;  // EU result arrives next cycle
    localparam logic [1:0] FWD_CYC_NOW  = 2'b01;  // EU result is on the bus this cycle
    localparam logic [1:0] FWD_CYC_NONE = 2'b00;  // use the (possibly patched) payload value

    typedef struct packed {
        logic [1:0]      rs1_forward_cycle;
        logic [ID_W-1:0] rs1_forward_id;
        logic [1:0]      rs2_forward_cycle;
        logic [ID_W-1:0] rs2_forward_id;
        logic [1:0]      rs3_forward_cycle;
        logic [ID_W-1:0] rs3_forward_id;
    } fwd_pkg;

    typedef struct packed {
        logic [7:0]           uop;
        logic [5:0]           rob_id;
        logic [PREG_W-1:0]    rd_preg;
        logic [REG_WIDTH-1:0] reg_rs1_val;
        logic [REG_WIDTH-1:0] reg_rs2_val;
        logic [REG_WIDTH-1:0] reg_rs3_val;
        fwd_pkg               fwd_pld;
    } eu_pkg;

endpackage

// File: rtl/toy_eu_fwd_src_match.sv
// Purpose: priority match of one source preg against pre-wakeup tags, live writebacks and writeback history.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs within the same cycle.
module toy_eu_fwd_src_match
    import toy_eu_forward_tag_gen_pkg::*;
(
    input  logic                                              rs_en,
    input  logic [PREG_W-1:0]                                 rs_preg,
    input  logic [REG_WIDTH-1:0]                              rf_val,
    input  logic                                              cancel_en,
    input  logic [EU_NUM-1:0]                                 pre_en,
    input  logic [EU_NUM-1:0][PREG_W-1:0]                     pre_preg,
    input  logic [EU_NUM-1:0]                                 wb_en,
    input  logic [EU_NUM-1:0][PREG_W-1:0]                     wb_preg,
    input  logic [EU_NUM-1:0][REG_WIDTH-1:0]                  wb_data,
    input  logic [RF_WR_LAT-1:0][EU_NUM-1:0]                  hist_vld,
    input  logic [RF_WR_LAT-1:0][EU_NUM-1:0][PREG_W-1:0]      hist_preg,
    input  logic [RF_WR_LAT-1:0][EU_NUM-1:0][REG_WIDTH-1:0]   hist_data,
    output logic [1:0]                                        fwd_cycle,
    output logic [ID_W-1:0]                                   fwd_id,
    output logic [REG_WIDTH-1:0]                              fwd_val,
    output logic                                              hit_pre
);

    logic                 src_live;
    logic                 pre_hit;
    logic [ID_W-1:0]      pre_id;
    logic                 wb_hit;
    logic [ID_W-1:0]      wb_id;
    logic [REG_WIDTH-1:0] wb_val;
    logic                 h_hit;
    logic [REG_WIDTH-1:0] h_val;

    // preg 0 is the hard-zero register and never takes a forwarded value.
    assign src_live = rs_en && (rs_preg != '0);

    // Per-level first match; lowest EU index wins, and for history the youngest stage wins.
    always_comb begin
        pre_hit = 1'b0;
        pre_id  = '0;
        wb_hit  = 1'b0;
        wb_id   = '0;
        wb_val  = '0;
        h_hit   = 1'b0;
        h_val   = '0;
        for (int i = 0; i < EU_NUM; i++) begin
            if (!pre_hit && pre_en[i] && (pre_preg[i] == rs_preg)) begin
                pre_hit = 1'b1;
                pre_id  = ID_W'(i);
            end
            if (!wb_hit && wb_en[i] && (wb_preg[i] == rs_preg)) begin
                wb_hit = 1'b1;
                wb_id  = ID_W'(i);
                wb_val = wb_data[i];
            end
        end
        for (int k = 0; k < RF_WR_LAT; k++) begin
            for (int i = 0; i < EU_NUM; i++) begin
                if (!h_hit && hist_vld[k][i] && (hist_preg[k][i] == rs_preg)) begin
                    h_hit = 1'b1;
                    h_val = hist_data[k][i];
                end
            end
        end
    end

    // Youngest producer wins: pre tag, then live writeback, then history; cancelled pre tags drop out.
    always_comb begin
        fwd_cycle = FWD_CYC_NONE;
        fwd_id    = '0;
        fwd_val   = rf_val;
        if (src_live) begin
            if (pre_hit && !cancel_en) begin
                fwd_cycle = FWD_CYC_NEXT;
                fwd_id    = pre_id;
            end else if (wb_hit) begin
                fwd_cycle = FWD_CYC_NOW;
                fwd_id    = wb_id;
                fwd_val   = wb_val;
            end else if (h_hit) begin
                fwd_val   = h_val;
            end
        end
    end

    assign hit_pre = src_live && pre_hit;

endmodule

// File: rtl/toy_eu_forward_tag_gen.sv
// Purpose: fill forwarding tags for issued ops and patch operands the regfile cannot see yet.
// Latency: issue path combinational; writeback history is RF_WR_LAT register stages per EU.
// Backpressure: none; eu_en drops when cancel_en kills the issue, history keeps shifting regardless.
module toy_eu_forward_tag_gen
    import toy_eu_forward_tag_gen_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cancel_en,
    input  logic [EU_NUM-1:0]                  eu_pre_en,
    input  logic [EU_NUM-1:0][PREG_W-1:0]      eu_pre_preg,
    input  logic [EU_NUM-1:0]                  eu_wb_en,
    input  logic [EU_NUM-1:0][PREG_W-1:0]      eu_wb_preg,
    input  logic [EU_NUM-1:0][REG_WIDTH-1:0]   v_forward_data,
    input  logic                               iss_en,
    input  eu_pkg                              iss_pld,
    input  logic [2:0]                         iss_rs_en,
    input  logic [2:0][PREG_W-1:0]             iss_rs_preg,
    output logic                               eu_en,
    output eu_pkg                              eu_pld,
    output logic                               pre_cancel_hit
);

    // Stage 0 holds h[1] (written last cycle); the last stage is about to become RF-visible.
    logic [RF_WR_LAT-1:0][EU_NUM-1:0]                hist_vld_q, hist_vld_d;
    logic [RF_WR_LAT-1:0][EU_NUM-1:0][PREG_W-1:0]    hist_preg_q, hist_preg_d;
    logic [RF_WR_LAT-1:0][EU_NUM-1:0][REG_WIDTH-1:0] hist_data_q, hist_data_d;

    logic [2:0][REG_WIDTH-1:0] rf_val;
    logic [2:0][1:0]           m_cycle;
    logic [2:0][ID_W-1:0]      m_id;
    logic [2:0][REG_WIDTH-1:0] m_val;
    logic [2:0]                m_hit_pre;

    // Shift the writeback history; writes to preg 0 are never recorded.
    always_comb begin
        hist_vld_d  = hist_vld_q;
        hist_preg_d = hist_preg_q;
        hist_data_d = hist_data_q;
        for (int i = 0; i < EU_NUM; i++) begin
            hist_vld_d[0][i]  = eu_wb_en[i] && (eu_wb_preg[i] != '0);
            hist_preg_d[0][i] = eu_wb_preg[i];
            hist_data_d[0][i] = v_forward_data[i];
        end
        for (int k = 1; k < RF_WR_LAT; k++) begin
            hist_vld_d[k]  = hist_vld_q[k-1];
            hist_preg_d[k] = hist_preg_q[k-1];
            hist_data_d[k] = hist_data_q[k-1];
        end
    end

    // History registers; not flushed by cancel because writebacks are final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld_q  <= '0;
            hist_preg_q <= '0;
            hist_data_q <= '0;
        end else begin
            hist_vld_q  <= hist_vld_d;
            hist_preg_q <= hist_preg_d;
            hist_data_q <= hist_data_d;
        end
    end

    assign rf_val[0] = iss_pld.reg_rs1_val;
    assign rf_val[1] = iss_pld.reg_rs2_val;
    assign rf_val[2] = iss_pld.reg_rs3_val;

    for (genvar s = 0; s < 3; s++) begin : g_src
        toy_eu_fwd_src_match u_match (
            .rs_en     (iss_rs_en[s]),
            .rs_preg   (iss_rs_preg[s]),
            .rf_val    (rf_val[s]),
            .cancel_en (cancel_en),
            .pre_en    (eu_pre_en),
            .pre_preg  (eu_pre_preg),
            .wb_en     (eu_wb_en),
            .wb_preg   (eu_wb_preg),
            .wb_data   (v_forward_data),
            .hist_vld  (hist_vld_q),
            .hist_preg (hist_preg_q),
            .hist_data (hist_data_q),
            .fwd_cycle (m_cycle[s]),
            .fwd_id    (m_id[s]),
            .fwd_val   (m_val[s]),
            .hit_pre   (m_hit_pre[s])
        );
    end

    // Copy the issued payload and overwrite only operand values and forwarding tags.
    always_comb begin
        eu_pld                           = iss_pld;
        eu_pld.reg_rs1_val               = m_val[0];
        eu_pld.reg_rs2_val               = m_val[1];
        eu_pld.reg_rs3_val               = m_val[2];
        eu_pld.fwd_pld.rs1_forward_cycle = m_cycle[0];
        eu_pld.fwd_pld.rs1_forward_id    = m_id[0];
        eu_pld.fwd_pld.rs2_forward_cycle = m_cycle[1];
        eu_pld.fwd_pld.rs2_forward_id    = m_id[1];
        eu_pld.fwd_pld.rs3_forward_cycle = m_cycle[2];
        eu_pld.fwd_pld.rs3_forward_id    = m_id[2];
    end

    assign eu_en          = iss_en && !cancel_en;
    assign pre_cancel_hit = iss_en && cancel_en && (|m_hit_pre);

endmodule

// File: tb/tb_toy_eu_forward_tag_gen.sv
// Purpose: directed checks of forwarding tags, operand patching, cancel and reset for the tag generator.
// Latency: inputs applied after the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_toy_eu_forward_tag_gen;
    import toy_eu_forward_tag_gen_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               cancel_en;
    logic [EU_NUM-1:0]                  eu_pre_en;
    logic [EU_NUM-1:0][PREG_W-1:0]      eu_pre_preg;
    logic [EU_NUM-1:0]                  eu_wb_en;
    logic [EU_NUM-1:0][PREG_W-1:0]      eu_wb_preg;
    logic [EU_NUM-1:0][REG_WIDTH-1:0]   v_forward_data;
    logic                               iss_en;
    eu_pkg                              iss_pld;
    logic [2:0]                         iss_rs_en;
    logic [2:0][PREG_W-1:0]             iss_rs_preg;
    logic                               eu_en;
    eu_pkg                              eu_pld;
    logic                               pre_cancel_hit;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    toy_eu_forward_tag_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cancel_en      (cancel_en),
        .eu_pre_en      (eu_pre_en),
        .eu_pre_preg    (eu_pre_preg),
        .eu_wb_en       (eu_wb_en),
        .eu_wb_preg     (eu_wb_preg),
        .v_forward_data (v_forward_data),
        .iss_en         (iss_en),
        .iss_pld        (iss_pld),
        .iss_rs_en      (iss_rs_en),
        .iss_rs_preg    (iss_rs_preg),
        .eu_en          (eu_en),
        .eu_pld         (eu_pld),
        .pre_cancel_hit (pre_cancel_hit)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_src(input string tag, input int s, input logic [1:0] cyc,
                           input logic [1:0] id, input logic [63:0] val);
        logic [1:0]  c;
        logic [1:0]  d;
        logic [63:0] v;
        case (s)
            0:       begin c = eu_pld.fwd_pld.rs1_forward_cycle; d = eu_pld.fwd_pld.rs1_forward_id; v = eu_pld.reg_rs1_val; end
            1:       begin c = eu_pld.fwd_pld.rs2_forward_cycle; d = eu_pld.fwd_pld.rs2_forward_id; v = eu_pld.reg_rs2_val; end
            default: begin c = eu_pld.fwd_pld.rs3_forward_cycle; d = eu_pld.fwd_pld.rs3_forward_id; v = eu_pld.reg_rs3_val; end
        endcase
        chk({tag, ".cyc"}, 64'(c), 64'(cyc));
        chk({tag, ".id"},  64'(d), 64'(id));
        chk({tag, ".val"}, v, val);
    endtask

    // Quiet inputs; RF read values are fixed per source so patching is visible.
    task automatic idle();
        cancel_en      = 1'b0;
        eu_pre_en      = '0;
        eu_pre_preg    = '0;
        eu_wb_en       = '0;
        eu_wb_preg     = '0;
        v_forward_data = '0;
        iss_en         = 1'b0;
        iss_rs_en      = '0;
        iss_rs_preg    = '0;
        iss_pld             = '0;
        iss_pld.uop         = 8'h5A;
        iss_pld.rob_id      = 6'd3;
        iss_pld.rd_preg     = 7'h7F;
        iss_pld.reg_rs1_val = 64'h1111;
        iss_pld.reg_rs2_val = 64'h2222;
        iss_pld.reg_rs3_val = 64'h3333;
        iss_pld.fwd_pld     = '1;
    endtask

    task automatic issue(input logic [2:0] en, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
        iss_en         = 1'b1;
        iss_rs_en      = en;
        iss_rs_preg[0] = p1;
        iss_rs_preg[1] = p2;
        iss_rs_preg[2] = p3;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk("rst.eu_en", 64'(eu_en), 64'd0);
        chk("rst.pch", 64'(pre_cancel_hit), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b111, 7'h05, 7'h06, 7'h07);
        #1;
        chk_src("rst.rs1", 0, 2'b00, 2'd0, 64'h1111);

        // 1: pre tag on EU2
        @(negedge clk); idle();
        eu_pre_en[2] = 1'b1; eu_pre_preg[2] = 7'h15;
        issue(3'b001, 7'h15, 7'h00, 7'h00);
        #1;
        chk("t1.eu_en", 64'(eu_en), 64'd1);
        chk_src("t1.rs1", 0, 2'b10, 2'd2, 64'h1111);
        chk("t1.uop", 64'(eu_pld.uop), 64'h5A);

        // 2: live writeback on EU1
        @(negedge clk); idle();
        eu_wb_en[1] = 1'b1; eu_wb_preg[1] = 7'h20; v_forward_data[1] = 64'hDEAD;
        issue(3'b010, 7'h00, 7'h20, 7'h00);
        #1;
        chk_src("t2.rs2", 1, 2'b01, 2'd1, 64'hDEAD);

        // 3: history lasts RF_WR_LAT cycles
        @(negedge clk); idle();
        eu_wb_en[0] = 1'b1; eu_wb_preg[0] = 7'h30; v_forward_data[0] = 64'hBEEF;
        @(negedge clk); idle();
        issue(3'b100, 7'h00, 7'h00, 7'h30);
        #1;
        chk_src("t3.h1", 2, 2'b00, 2'd0, 64'hBEEF);
        @(negedge clk); idle();
        issue(3'b100, 7'h00, 7'h00, 7'h30);
        #1;
        chk_src("t3.h2", 2, 2'b00, 2'd0, 64'hBEEF);
        @(negedge clk); idle();
        issue(3'b100, 7'h00, 7'h00, 7'h30);
        #1;
        chk_src("t3.rf", 2, 2'b00, 2'd0, 64'h3333);

        // 4: cancel kills pre tags but writebacks still enter history
        @(negedge clk); idle();
        cancel_en = 1'b1;
        eu_pre_en[0] = 1'b1; eu_pre_preg[0] = 7'h11;
        eu_wb_en[2] = 1'b1; eu_wb_preg[2] = 7'h40; v_forward_data[2] = 64'h4040;
        issue(3'b001, 7'h11, 7'h00, 7'h00);
        #1;
        chk("t4.eu_en", 64'(eu_en), 64'd0);
        chk("t4.pch", 64'(pre_cancel_hit), 64'd1);
        chk_src("t4.rs1", 0, 2'b00, 2'd0, 64'h1111);
        @(negedge clk); idle();
        cancel_en = 1'b1;
        issue(3'b011, 7'h12, 7'h40, 7'h00);
        #1;
        chk("t4.pch_miss", 64'(pre_cancel_hit), 64'd0);
        chk_src("t4.hist", 1, 2'b00, 2'd0, 64'h4040);

        // 5: pre beats wb on the same preg
        @(negedge clk); idle();
        eu_pre_en[0] = 1'b1; eu_pre_preg[0] = 7'h08;
        eu_wb_en[3] = 1'b1; eu_wb_preg[3] = 7'h08; v_forward_data[3] = 64'h0808;
        issue(3'b001, 7'h08, 7'h00, 7'h00);
        #1;
        chk_src("t5.rs1", 0, 2'b10, 2'd0, 64'h1111);

        // mixed: pre tie (lowest EU wins), wb on rs2, preg 0 never matches
        @(negedge clk); idle();
        eu_pre_en = 4'b1011;
        eu_pre_preg[3] = 7'h60; eu_pre_preg[1] = 7'h60; eu_pre_preg[0] = 7'h00;
        eu_wb_en = 4'b0101;
        eu_wb_preg[2] = 7'h61; v_forward_data[2] = 64'h6161;
        eu_wb_preg[0] = 7'h00; v_forward_data[0] = 64'h9999;
        issue(3'b111, 7'h60, 7'h61, 7'h00);
        #1;
        chk_src("mix.rs1", 0, 2'b10, 2'd1, 64'h1111);
        chk_src("mix.rs2", 1, 2'b01, 2'd2, 64'h6161);
        chk_src("mix.rs3", 2, 2'b00, 2'd0, 64'h3333);
        @(negedge clk); idle();
        issue(3'b100, 7'h00, 7'h00, 7'h00);
        #1;
        chk_src("mix.zero_h", 2, 2'b00, 2'd0, 64'h3333);

        // 6: reset clears history mid-stream
        @(negedge clk); idle();
        eu_wb_en[2] = 1'b1; eu_wb_preg[2] = 7'h50; v_forward_data[2] = 64'hAAAA;
        @(negedge clk); idle();
        eu_wb_en[3] = 1'b1; eu_wb_preg[3] = 7'h51; v_forward_data[3] = 64'hBBBB;
        @(negedge clk); idle();
        issue(3'b011, 7'h50, 7'h51, 7'h00);
        #1;
        chk_src("t6.pre_rs1", 0, 2'b00, 2'd0, 64'hAAAA);
        chk_src("t6.pre_rs2", 1, 2'b00, 2'd0, 64'hBBBB);
        rst_n = 1'b0;
        #1;
        chk_src("t6.rst_rs1", 0, 2'b00, 2'd0, 64'h1111);
        chk_src("t6.rst_rs2", 1, 2'b00, 2'd0, 64'h2222);
        rst_n = 1'b1;
        #1;
        chk_src("t6.post_rs2", 1, 2'b00, 2'd0, 64'h2222);
        @(negedge clk); idle();
        issue(3'b010, 7'h00, 7'h51, 7'h00);
        #1;
        chk_src("t6.next_rs2", 1, 2'b00, 2'd0, 64'h2222);

        // idle issue: outputs quiet
        @(negedge clk); idle();
        cancel_en = 1'b1;
        eu_pre_en[1] = 1'b1; eu_pre_preg[1] = 7'h22;
        #1;
        chk("idle.eu_en", 64'(eu_en), 64'd0);
        chk("idle.pch", 64'(pre_cancel_hit), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
